// File: rtl/keccak_nonce_checker.sv
// Golden-nonce checker behind the keccak512 pipeline: nonce delay line,
// share-target compare and a small valid/ready FIFO of winning nonces.
module keccak_nonce_checker #(
  parameter int LATENCY    = 98,
  parameter int FIFO_DEPTH = 8,
  parameter int NONCE_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [NONCE_W-1:0] issue_nonce,
  input  logic               work_flush,
  input  logic [511:0]       hash,
  input  logic [63:0]        target,
  output logic               gn_valid,
  output logic [NONCE_W-1:0] gn_nonce,
  input  logic               gn_ready,
  output logic               overflow,
  output logic [31:0]        hash_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [LATENCY-1:0] dl_v_q;
  logic [NONCE_W-1:0] dl_n_q [LATENCY];
  logic               dl_last_v;
  logic [NONCE_W-1:0] dl_last_n;

  logic               hit_cmp;
  logic               c1_hit_q;
  logic               c1_hit_d;
  logic [NONCE_W-1:0] c1_nonce_q;

  logic [NONCE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_q, wr_d;
  logic [AW:0]        rd_q, rd_d;
  logic               full, empty;
  logic               push_hit, push, pop;

  logic               ovf_q, ovf_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               unused_hash;

  assign unused_hash = ^hash[511:64];
  assign dl_last_v   = dl_v_q[LATENCY-1];
  assign dl_last_n   = dl_n_q[LATENCY-1];

  // An issue in the flush cycle enters stage 0 and survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_v_q <= '0;
    end else begin
      dl_v_q[0] <= issue_valid;
      for (int i = 1; i < LATENCY; i++) begin
        dl_v_q[i] <= dl_v_q[i-1] & ~work_flush;
      end
    end
  end

  always_ff @(posedge clk) begin
    dl_n_q[0] <= issue_nonce;
    for (int i = 1; i < LATENCY; i++) begin
      dl_n_q[i] <= dl_n_q[i-1];
    end
  end

  always_comb begin
    hit_cmp  = hash[63:0] <= target;
    c1_hit_d = dl_last_v & hit_cmp & ~work_flush;
    cnt_d    = cnt_q + {31'd0, dl_last_v};
  end

  always_comb begin
    empty    = wr_q == rd_q;
    full     = (wr_q[AW] != rd_q[AW]) &&
               (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop      = gn_ready & ~empty;
    // A hit sitting in C1 is still in flight and dies with the flush.
    push_hit = c1_hit_q & ~work_flush;
    push     = push_hit & (~full | pop);
    wr_d     = wr_q + {{AW{1'b0}}, push};
    rd_d     = rd_q + {{AW{1'b0}}, pop};
    ovf_d    = ovf_q | (push_hit & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c1_hit_q <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      c1_hit_q <= c1_hit_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    c1_nonce_q <= dl_last_n;
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= c1_nonce_q;
    end
  end

  assign gn_valid   = ~empty;
  assign gn_nonce   = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign overflow   = ovf_q;
  assign hash_count = cnt_q;

endmodule

// File: tb/tb_keccak_nonce_checker.sv
// Directed bench for keccak_nonce_checker: latency, target compare,
// flush, FIFO full/overflow and mid-run reset.
module tb_keccak_nonce_checker;

  localparam int L = 98;

  logic         clk = 1'b0;
  logic         reset;
  logic         issue_valid;
  logic [31:0]  issue_nonce;
  logic         work_flush;
  logic [511:0] hash;
  logic [63:0]  target;
  logic         gn_valid;
  logic [31:0]  gn_nonce;
  logic         gn_ready;
  logic         overflow;
  logic [31:0]  hash_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  keccak_nonce_checker dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_nonce (issue_nonce),
    .work_flush  (work_flush),
    .hash        (hash),
    .target      (target),
    .gn_valid    (gn_valid),
    .gn_nonce    (gn_nonce),
    .gn_ready    (gn_ready),
    .overflow    (overflow),
    .hash_count  (hash_count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] nonce);
    issue_valid = 1'b1;
    issue_nonce = nonce;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [31:0] base,
                       input int cnt);
    for (int k = 0; k < cnt; k++) begin
      chk({tag, "_v"}, 64'(gn_valid), 64'd1);
      chk({tag, "_n"}, 64'(gn_nonce), 64'(base + 32'(k)));
      gn_ready = 1'b1;
      tick();
      gn_ready = 1'b0;
    end
    chk({tag, "_empty"}, 64'(gn_valid), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_nonce = '0;
    work_flush  = 1'b0;
    gn_ready    = 1'b0;
    target      = '1;
    hash        = {8{64'h5a5a_0000_0000_0001}};
    tick(3);
    reset = 1'b0;
    chk("rst_valid", 64'(gn_valid), 64'd0);
    chk("rst_nonce", 64'(gn_nonce), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_cnt", 64'(hash_count), 64'd0);

    // 1: single issue, exact latency
    issue(32'h0000_1234);
    tick(L);
    chk("t1_early", 64'(gn_valid), 64'd0);
    chk("t1_cnt", 64'(hash_count), 64'd1);
    tick();
    chk("t1_valid", 64'(gn_valid), 64'd1);
    chk("t1_nonce", 64'(gn_nonce), 64'h1234);
    tick(3);
    chk("t1_hold", 64'(gn_nonce), 64'h1234);
    drain("t1_pop", 32'h1234, 1);

    // 2: 200 misses, then hash == target boundary hit
    do_reset();
    target = 64'd0;
    for (int i = 0; i < 200; i++) begin
      issue(32'(i));
    end
    tick(L + 3);
    chk("t2_valid", 64'(gn_valid), 64'd0);
    chk("t2_cnt", 64'(hash_count), 64'd200);
    chk("t2_ovf", 64'(overflow), 64'd0);
    target = 64'h5a5a_0000_0000_0001;
    issue(32'h77);
    tick(L + 1);
    chk("t2_eq_valid", 64'(gn_valid), 64'd1);
    chk("t2_eq_nonce", 64'(gn_nonce), 64'h77);
    gn_ready = 1'b1;
    tick();
    gn_ready = 1'b0;
    target = 64'h5a5a_0000_0000_0000;
    issue(32'h78);
    tick(L + 3);
    chk("t2_gt_valid", 64'(gn_valid), 64'd0);
    chk("t2_gt_cnt", 64'(hash_count), 64'd202);

    // 3: ten hits into an eight-entry FIFO
    do_reset();
    target = '1;
    for (int i = 0; i < 10; i++) begin
      issue(32'hA0 + 32'(i));
    end
    tick(L - 1);
    chk("t3_full_ovf", 64'(overflow), 64'd0);
    tick();
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_head", 64'(gn_nonce), 64'hA0);
    tick(3);
    drain("t3_drain", 32'hA0, 8);
    chk("t3_sticky", 64'(overflow), 64'd1);

    // 4: flush discards in-flight, keeps same-cycle issue
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(32'hC0 + 32'(i));
    end
    tick(4);
    work_flush = 1'b1;
    issue(32'hCF);
    work_flush = 1'b0;
    tick(L + 3);
    chk("t4_cnt", 64'(hash_count), 64'd1);
    drain("t4_new", 32'hCF, 1);

    // 5: push and pop together while full
    do_reset();
    for (int i = 0; i < 9; i++) begin
      issue(32'hB0 + 32'(i));
    end
    tick(L);
    chk("t5_full_head", 64'(gn_nonce), 64'hB0);
    gn_ready = 1'b1;
    tick();
    gn_ready = 1'b0;
    chk("t5_ovf", 64'(overflow), 64'd0);
    tick(2);
    drain("t5_drain", 32'hB1, 8);
    chk("t5_ovf_end", 64'(overflow), 64'd0);

    // 6: reset mid-run with entries queued and nonces in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(32'hD0 + 32'(i));
    end
    tick(L + 3);
    chk("t6_pending", 64'(gn_valid), 64'd1);
    issue(32'hE0);
    issue(32'hE1);
    tick(49);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", 64'(gn_valid), 64'd0);
    chk("t6_nonce", 64'(gn_nonce), 64'd0);
    chk("t6_cnt", 64'(hash_count), 64'd0);
    tick(L + 5);
    chk("t6_late_valid", 64'(gn_valid), 64'd0);
    chk("t6_late_cnt", 64'(hash_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
